// File: rtl/seg7_scan_display.sv
// Four-digit hex scanner for a common-anode 7-segment bank.
// Guarded digit slots, frame-synchronous value updates.
module seg7_scan_display #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int GUARD_CYC = 500
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  duan_ma,
  output logic [3:0]  wei_ma,
  output logic        upd_pend,
  output logic        frame_tick
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic {
    GUARD,
    SHOW
  } state_t;

  // With no guard interval every slot opens directly in SHOW.
  localparam state_t ST0 = (GUARD_CYC == 0) ? SHOW : GUARD;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow, active;
  logic [3:0]    shadow_dp, active_dp;

  logic [3:0] nib;
  logic       hi_zero;
  logic       dp_on;
  logic [6:0] code;
  logic [7:0] seg_nxt;
  logic       last_slot;
  logic       wrap;

  always_comb begin
    nib     = 4'h0;
    hi_zero = 1'b0;
    unique case (idx)
      2'd0: begin
        nib     = active[3:0];
        hi_zero = 1'b0;
      end
      2'd1: begin
        nib     = active[7:4];
        hi_zero = (active[15:4] == 12'h000);
      end
      2'd2: begin
        nib     = active[11:8];
        hi_zero = (active[15:8] == 8'h00);
      end
      2'd3: begin
        nib     = active[15:12];
        hi_zero = (active[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    code = 7'h7F;
    unique case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      4'hF: code = 7'h0E;
    endcase
  end

  always_comb begin
    dp_on   = active_dp[idx];
    seg_nxt = {~dp_on, (blank_lz && hi_zero) ? 7'h7F : code};
  end

  assign last_slot = (cnt == LAST);
  assign wrap      = en && last_slot && (idx == 2'd3);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state      <= ST0;
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      shadow_dp  <= 4'h0;
      active     <= 16'h0000;
      active_dp  <= 4'h0;
      upd_pend   <= 1'b0;
      frame_tick <= 1'b0;
      duan_ma    <= 8'hFF;
      wei_ma     <= 4'hF;
    end else begin
      frame_tick <= wrap;
      if (load) begin
        shadow    <= din;
        shadow_dp <= dp_in;
        upd_pend  <= 1'b1;
      end
      // Wrap is the only point the shown value may change.
      if (wrap) begin
        if (load) begin
          active    <= din;
          active_dp <= dp_in;
          upd_pend  <= 1'b0;
        end else if (upd_pend) begin
          active    <= shadow;
          active_dp <= shadow_dp;
          upd_pend  <= 1'b0;
        end
      end
      if (!en) begin
        state   <= ST0;
        cnt     <= '0;
        idx     <= 2'd0;
        duan_ma <= 8'hFF;
        wei_ma  <= 4'hF;
      end else begin
        if (state == SHOW) begin
          duan_ma <= seg_nxt;
          wei_ma  <= ~(4'b0001 << idx);
        end else begin
          duan_ma <= 8'hFF;
          wei_ma  <= 4'hF;
        end
        if (last_slot) begin
          cnt   <= '0;
          idx   <= idx + 2'd1;
          state <= ST0;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= ((int'(cnt) + 1) < GUARD_CYC) ? GUARD : SHOW;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed scenarios plus random traffic
// compared each cycle against a frame-position reference model.
module tb_seg7_scan_display;

  localparam int DW   = 10;
  localparam int GC   = 2;
  localparam int FRM  = 4 * DW;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  duan_ma;
  logic [3:0]  wei_ma;
  logic        upd_pend;
  logic        frame_tick;

  seg7_scan_display #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .GUARD_CYC(GC)
  ) dut (
    .clk_50M(clk_50M),
    .rst(rst),
    .en(en),
    .load(load),
    .din(din),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .duan_ma(duan_ma),
    .wei_ma(wei_ma),
    .upd_pend(upd_pend),
    .frame_tick(frame_tick)
  );

  always #5 clk_50M = ~clk_50M;

  logic [7:0] codes [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int checks = 0;
  int errors = 0;
  int ft_cnt = 0;

  // Reference state: cycles since scan start plus the three value stores.
  int          t;
  logic [15:0] m_sh, m_act;
  logic [3:0]  m_shdp, m_actdp;
  logic        m_pend;
  logic [7:0]  e_d;
  logic [3:0]  e_w;
  logic        e_ft;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] lit(input int slot, input logic [15:0] v,
                                     input logic [3:0] dp, input logic blz);
    logic [15:0] upper;
    logic [3:0]  n;
    logic [7:0]  s;
    upper = v >> (4 * slot);
    n     = upper[3:0];
    s     = codes[n];
    if (blz && slot > 0 && upper == 16'h0) s = 8'hFF;
    if (dp[slot]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic check_outs(input string tag);
    int lows;
    chk({tag, ".duan"}, {8'h0, duan_ma}, {8'h0, e_d});
    chk({tag, ".wei"}, {12'h0, wei_ma}, {12'h0, e_w});
    chk({tag, ".pend"}, {15'h0, upd_pend}, {15'h0, m_pend});
    chk({tag, ".tick"}, {15'h0, frame_tick}, {15'h0, e_ft});
    lows = 0;
    for (int i = 0; i < 4; i++) if (!wei_ma[i]) lows++;
    chk({tag, ".onehot"}, 16'(lows <= 1), 16'h1);
  endtask

  task automatic model_edge();
    int pos, slot, off;
    logic wrap;
    if (!en) begin
      e_d  = 8'hFF;
      e_w  = 4'hF;
      e_ft = 1'b0;
      if (load) begin
        m_sh = din; m_shdp = dp_in; m_pend = 1'b1;
      end
      t = 0;
    end else begin
      pos  = t % FRM;
      slot = pos / DW;
      off  = pos % DW;
      wrap = (pos == FRM - 1);
      if (off < GC) begin
        e_d = 8'hFF;
        e_w = 4'hF;
      end else begin
        e_d = lit(slot, m_act, m_actdp, blank_lz);
        e_w = 4'hF & ~(4'b0001 << slot);
      end
      e_ft = wrap;
      if (wrap) begin
        if (load) begin
          m_act = din; m_actdp = dp_in; m_pend = 1'b0;
        end else if (m_pend) begin
          m_act = m_sh; m_actdp = m_shdp; m_pend = 1'b0;
        end
      end else if (load) begin
        m_sh = din; m_shdp = dp_in; m_pend = 1'b1;
      end
      t++;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk_50M);
    #1;
    if (frame_tick) ft_cnt++;
    check_outs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    load  = 1'b1;
    din   = d;
    dp_in = dp;
    tick("load");
    load  = 1'b0;
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < FRM && (t % FRM) != p; i++) tick("seek");
    chk("seek", 16'(t % FRM), 16'(p));
  endtask

  task automatic do_reset();
    load = 1'b0;
    rst  = 1'b1;
    #1;
    t = 0;
    m_sh = 16'h0; m_shdp = 4'h0; m_act = 16'h0; m_actdp = 4'h0;
    m_pend = 1'b0;
    e_d = 8'hFF; e_w = 4'hF; e_ft = 1'b0;
    check_outs("rst_async");
    @(posedge clk_50M);
    #1;
    check_outs("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0;
    din = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    #2;
    do_reset();

    // Scenario 1: basic scan of 1234
    en = 1'b1;
    do_load(16'h1234, 4'h0);
    run(FRM + 5, "s1");
    goto_pos(FRM - 1);
    tick("s1w");
    goto_pos(GC + 1);
    chk("s1.dig0", {8'h0, duan_ma}, 16'h0099);
    chk("s1.wei0", {12'h0, wei_ma}, 16'h000E);
    ft_cnt = 0;
    run(FRM, "s1f");
    chk("s1.ticks", 16'(ft_cnt), 16'd1);

    // Scenario 2: blanking and decimal point
    blank_lz = 1'b1;
    do_load(16'h00A0, 4'b0100);
    run(2 * FRM, "s2lz");
    blank_lz = 1'b0;
    run(FRM, "s2nolz");

    // Scenario 3: mid-frame load held until wrap
    do_load(16'h1234, 4'h0);
    goto_pos(FRM - 1);
    tick("s3w");
    goto_pos(DW + 5);
    do_load(16'hFFFF, 4'h0);
    ft_cnt = 0;
    run(2 * FRM, "s3");
    chk("s3.ticks", 16'(ft_cnt), 16'd2);

    // Scenario 4: back-to-back loads, then one on the wrap
    goto_pos(5);
    do_load(16'h5555, 4'h0);
    do_load(16'h6666, 4'h0);
    goto_pos(FRM - 1);
    do_load(16'h7777, 4'h0);
    chk("s4.pend", {15'h0, upd_pend}, 16'h0);
    run(FRM + 3, "s4");

    // Scenario 5: enable drop mid digit 2
    goto_pos(2 * DW + 5);
    en = 1'b0;
    run(15, "s5off");
    en = 1'b1;
    run(FRM, "s5on");

    // Scenario 6: reset with update pending
    do_load(16'h4321, 4'hF);
    goto_pos(2 * DW + 5);
    chk("s6.pend", {15'h0, upd_pend}, 16'h1);
    en = 1'b0;
    do_reset();
    en = 1'b1;
    run(FRM + 5, "s6");

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 79) == 0) en = ~en;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      load  = ($urandom_range(0, 15) == 0);
      din   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) din[15:8] = 8'h00;
      dp_in = 4'($urandom);
      tick("rnd");
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
